// File: rtl/step_scheduler.sv
// step_scheduler: master step-timing controller for the step sequencer.
// It divides the clock into step strobes, walks StepIdx over STEPS columns,
// fires per-track triggers from the pattern grid, counts pattern loops and
// gates Play for the sample players.
// Optional feature macro: SWING_EN. When it is defined, the Swing input is
// added and even/odd steps are lengthened/shortened by the same amount.
// Start and Stop are single-cycle command pulses. There is no ready/ack:
// a pulse is acted on at the edge where it is sampled, and Stop beats Start
// when both are present in the same cycle.
module step_scheduler #(
  parameter int STEPS    = 16,
  parameter int TRACKS   = 4,
  parameter int PERIOD_W = 24,
  parameter int LOOP_W   = 7
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Stop,
  input  logic [PERIOD_W-1:0]       StepPeriod,
  input  logic [LOOP_W-1:0]         Loops,
  input  logic [TRACKS*STEPS-1:0]   Pattern,
`ifdef SWING_EN
  input  logic [PERIOD_W-2:0]       Swing,
`endif
  output logic                      Play,
  output logic                      Step,
  output logic [$clog2(STEPS)-1:0]  StepIdx,
  output logic [TRACKS-1:0]         Trig,
  output logic                      Done,
  output logic [1:0]                fsm_state
);

  localparam int IDX_W = $clog2(STEPS);
  localparam int CNT_W = PERIOD_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PERIOD_W-1:0] period_q;
  logic [LOOP_W-1:0]   loops_q;
  logic [LOOP_W-1:0]   loop_cnt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    dur;
  logic [IDX_W-1:0]    step_idx;
  logic                step_q;
  logic [PERIOD_W-1:0] period_in;
  logic                start_go;
  logic                step_end;
  logic                last_step;
  logic [STEPS-1:0]    row;

`ifdef SWING_EN
  logic [PERIOD_W-2:0] swing_q;
  logic [PERIOD_W-1:0] swing_lim;
  logic [PERIOD_W-2:0] swing_in;
`endif

  // Config capture values: period clamped to at least 2, swing limited to P/2.
  always_comb begin
    period_in = (StepPeriod < PERIOD_W'(2)) ? PERIOD_W'(2) : StepPeriod;
`ifdef SWING_EN
    swing_lim = period_in >> 1;
    swing_in  = ({1'b0, Swing} > swing_lim) ? swing_lim[PERIOD_W-2:0] : Swing;
`endif
  end

  // Length of the current step in cycles; swing stretches even steps and
  // shrinks odd ones so a pair of steps always spans 2*P.
  always_comb begin
`ifdef SWING_EN
    if (step_idx[0])
      dur = {1'b0, period_q} - {2'b00, swing_q};
    else
      dur = {1'b0, period_q} + {2'b00, swing_q};
`else
    dur = {1'b0, period_q};
`endif
  end

  // FSM next state, step-boundary detection and Moore outputs.
  always_comb begin
    state_next = state;
    start_go   = Start && !Stop;
    step_end   = (state == S_RUN) && (cnt == dur - CNT_W'(1));
    last_step  = (step_idx == IDX_W'(STEPS - 1)) && (loops_q != '0) &&
                 (loop_cnt == loops_q - LOOP_W'(1));
    case (state)
      S_IDLE: if (start_go) state_next = S_RUN;
      S_RUN: begin
        if (Stop)                       state_next = S_IDLE;
        else if (Start)                 state_next = S_RUN;
        else if (step_end && last_step) state_next = S_FIN;
      end
      S_FIN:   state_next = start_go ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    Play      = (state == S_RUN);
    Done      = (state == S_FIN);
    Step      = step_q;
    StepIdx   = step_idx;
    fsm_state = state;
  end

  // Triggers are taken live from the pattern during the strobe cycle only.
  always_comb begin
    row  = '0;
    Trig = '0;
    for (int t = 0; t < TRACKS; t++) begin
      row     = Pattern[t*STEPS +: STEPS];
      Trig[t] = step_q & row[step_idx];
    end
  end

  // FSM state register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Step timing datapath: config latch, period counter, step index, loops.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      period_q <= '0;
      loops_q  <= '0;
      loop_cnt <= '0;
      cnt      <= '0;
      step_idx <= '0;
      step_q   <= 1'b0;
`ifdef SWING_EN
      swing_q  <= '0;
`endif
    end else if (start_go) begin
      period_q <= period_in;
      loops_q  <= Loops;
      loop_cnt <= '0;
      cnt      <= '0;
      step_idx <= '0;
      step_q   <= 1'b1;
`ifdef SWING_EN
      swing_q  <= swing_in;
`endif
    end else if (state == S_RUN && !Stop && step_end && !last_step) begin
      cnt      <= '0;
      step_q   <= 1'b1;
      step_idx <= step_idx + IDX_W'(1);
      if (step_idx == IDX_W'(STEPS - 1) && loops_q != '0)
        loop_cnt <= loop_cnt + LOOP_W'(1);
    end else if (state == S_RUN && !Stop && !step_end) begin
      cnt    <= cnt + CNT_W'(1);
      step_q <= 1'b0;
    end else begin
      cnt      <= '0;
      step_q   <= 1'b0;
      step_idx <= '0;
      loop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: directed bench for step_scheduler (default build;
// the swing scenario is compiled in when SWING_EN is defined).
module tb_step_scheduler;

  localparam int STEPS    = 16;
  localparam int TRACKS   = 4;
  localparam int PERIOD_W = 24;
  localparam int LOOP_W   = 7;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     stop;
  logic [PERIOD_W-1:0]      step_period;
  logic [LOOP_W-1:0]        loops;
  logic [TRACKS*STEPS-1:0]  pattern;
`ifdef SWING_EN
  logic [PERIOD_W-2:0]      swing;
`endif
  logic                     play;
  logic                     step;
  logic [3:0]               step_idx;
  logic [TRACKS-1:0]        trig;
  logic                     done;
  logic [1:0]               fsm_state;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  step_scheduler #(
    .STEPS(STEPS), .TRACKS(TRACKS), .PERIOD_W(PERIOD_W), .LOOP_W(LOOP_W)
  ) dut (
    .Clock(clk), .Reset(rst), .Start(start), .Stop(stop),
    .StepPeriod(step_period), .Loops(loops), .Pattern(pattern),
`ifdef SWING_EN
    .Swing(swing),
`endif
    .Play(play), .Step(step), .StepIdx(step_idx), .Trig(trig),
    .Done(done), .fsm_state(fsm_state)
  );

  // Clock generation and run-time bound.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver: pulse Start for one cycle; called and returns at a negedge.
  task automatic start_play(input logic [PERIOD_W-1:0] p, input logic [LOOP_W-1:0] l);
    step_period = p;
    loops       = l;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // Driver: pulse Stop for one cycle, then one idle cycle.
  task automatic stop_play();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (play !== 1'b0) begin errors++; $display("FAIL por_play: got %0b expected 0", play); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL por_step: got %0b expected 0", step); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL por_done: got %0b expected 0", done); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL por_state: got %0d expected 0", fsm_state); end
    // Reset mid-run, landing on the edge that would otherwise strobe step 3.
    pattern = '1;
    start_play(24'd4, 7'd0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (play !== 1'b0) begin errors++; $display("FAIL rst_play: got %0b expected 0", play); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL rst_step: got %0b expected 0", step); end
    checks++; if (trig !== 4'h0) begin errors++; $display("FAIL rst_trig: got %h expected 0", trig); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", step_idx); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", fsm_state); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (play !== 1'b0) begin errors++; $display("FAIL rst_release_play: got %0b expected 0", play); end
  endtask

  // P=4, L=1: 16 strobes at cycles 1,5,..,61; Play for 64 cycles; Done at 65.
  task automatic test_loop_timing();
    int strobes, play_cnt, done_cnt, done_cyc, idx_at_done;
    logic [3:0] e;
    strobes = 0; play_cnt = 0; done_cnt = 0; done_cyc = -1; idx_at_done = -1;
    pattern = '0;
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
    start_play(24'd4, 7'd1);
    for (int c = 1; c <= 66; c++) begin
      if (play) play_cnt++;
      if (done) begin done_cnt++; done_cyc = c; idx_at_done = int'(step_idx); end
      if (step) begin
        strobes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL loop_strobe: extra strobe at cycle %0d, expected none", c);
        end else begin
          e = exp_q.pop_front();
          if (step_idx !== e || c != 1 + 4 * int'(e)) begin
            errors++;
            $display("FAIL loop_strobe: got idx %0d at cycle %0d expected idx %0d at cycle %0d",
                     step_idx, c, e, 1 + 4 * int'(e));
          end
        end
      end
      @(negedge clk);
    end
    checks++; if (strobes != 16) begin errors++; $display("FAIL loop_strobes: got %0d expected 16", strobes); end
    checks++; if (play_cnt != 64) begin errors++; $display("FAIL loop_play_len: got %0d expected 64", play_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL loop_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != 65) begin errors++; $display("FAIL loop_done_cyc: got %0d expected 65", done_cyc); end
    checks++; if (idx_at_done != 0) begin errors++; $display("FAIL loop_done_idx: got %0d expected 0", idx_at_done); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL loop_end_state: got %0d expected 0", fsm_state); end
  endtask

  // Track0 = 0x0101, track2 = 0x8000: Trig[0] at steps 0 and 8, Trig[2] at 15.
  task automatic test_pattern();
    logic [15:0] t0_mask, t2_mask;
    int t0_cnt, t2_cnt, other_cnt, stray_cnt;
    t0_mask = '0; t2_mask = '0; t0_cnt = 0; t2_cnt = 0; other_cnt = 0; stray_cnt = 0;
    pattern = {16'h0000, 16'h8000, 16'h0000, 16'h0101};
    start_play(24'd2, 7'd1);
    for (int c = 1; c <= 33; c++) begin
      if (!step && trig != 4'h0) stray_cnt++;
      if (step) begin
        if (trig[0]) begin t0_cnt++; t0_mask[step_idx] = 1'b1; end
        if (trig[2]) begin t2_cnt++; t2_mask[step_idx] = 1'b1; end
        if (trig[1] || trig[3]) other_cnt++;
      end
      @(negedge clk);
    end
    checks++; if (t0_mask !== 16'h0101) begin errors++; $display("FAIL pat_t0_steps: got %h expected 0101", t0_mask); end
    checks++; if (t0_cnt != 2) begin errors++; $display("FAIL pat_t0_cnt: got %0d expected 2", t0_cnt); end
    checks++; if (t2_mask !== 16'h8000) begin errors++; $display("FAIL pat_t2_steps: got %h expected 8000", t2_mask); end
    checks++; if (t2_cnt != 1) begin errors++; $display("FAIL pat_t2_cnt: got %0d expected 1", t2_cnt); end
    checks++; if (other_cnt != 0) begin errors++; $display("FAIL pat_other: got %0d expected 0", other_cnt); end
    checks++; if (stray_cnt != 0) begin errors++; $display("FAIL pat_stray: got %0d expected 0", stray_cnt); end
  endtask

  // L=0, P=3: endless play, wraps StepIdx, never Done; Stop ends it next edge.
  task automatic test_infinite_stop();
    int strobes, done_cnt, last_idx;
    strobes = 0; done_cnt = 0; last_idx = -1;
    pattern = '1;
    start_play(24'd3, 7'd0);
    for (int c = 1; c <= 332; c++) begin
      if (step) begin strobes++; last_idx = int'(step_idx); end
      if (done) done_cnt++;
      @(negedge clk);
    end
    checks++; if (strobes != 111) begin errors++; $display("FAIL inf_strobes: got %0d expected 111", strobes); end
    checks++; if (last_idx != 14) begin errors++; $display("FAIL inf_last_idx: got %0d expected 14", last_idx); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL inf_done: got %0d expected 0", done_cnt); end
    checks++; if (play !== 1'b1) begin errors++; $display("FAIL inf_play: got %0b expected 1", play); end
    // Cycle 333 here; without Stop, cycle 334 would carry a strobe.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (play !== 1'b0) begin errors++; $display("FAIL stop_play: got %0b expected 0", play); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL stop_step: got %0b expected 0", step); end
    checks++; if (trig !== 4'h0) begin errors++; $display("FAIL stop_trig: got %h expected 0", trig); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL stop_idx: got %0d expected 0", step_idx); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done: got %0b expected 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done_late: got %0b expected 0", done); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL stop_state: got %0d expected 0", fsm_state); end
  endtask

  // Start with Stop in IDLE is dropped; Stop alone in IDLE is ignored.
  task automatic test_start_stop_collision();
    int active;
    active = 0;
    step_period = 24'd4; loops = 7'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (play || step) active++;
      @(negedge clk);
    end
    checks++; if (active != 0) begin errors++; $display("FAIL collide_active: got %0d expected 0", active); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL collide_state: got %0d expected 0", fsm_state); end
  endtask

  // Start at step 7 restarts at step 0 next cycle and re-latches P and L.
  task automatic test_back_to_back();
    int found, gap, done_cyc;
    found = 0; gap = 0; done_cyc = -1;
    pattern = '0;
    start_play(24'd4, 7'd1);
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (step && step_idx == 4'd7) found = 1;
      else @(negedge clk);
    end
    checks++; if (found != 1) begin errors++; $display("FAIL restart_reach7: got %0d expected 1", found); end
    start_play(24'd5, 7'd2);
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL restart_step: got %0b expected 1", step); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL restart_idx: got %0d expected 0", step_idx); end
    checks++; if (play !== 1'b1) begin errors++; $display("FAIL restart_play: got %0b expected 1", play); end
    do begin
      @(negedge clk);
      gap++;
    end while (!step && gap < 20);
    checks++; if (gap != 5) begin errors++; $display("FAIL restart_gap: got %0d expected 5", gap); end
    checks++; if (step_idx !== 4'd1) begin errors++; $display("FAIL restart_idx1: got %0d expected 1", step_idx); end
    // Now at cycle 6 after the restart strobe (cycle 1); 32 steps of 5.
    for (int c = 6; c <= 165; c++) begin
      if (done) done_cyc = c;
      @(negedge clk);
    end
    checks++; if (done_cyc != 161) begin errors++; $display("FAIL restart_done_cyc: got %0d expected 161", done_cyc); end
  endtask

  // Start during FIN: Done still pulses, then play restarts on the same edge.
  task automatic test_fin_restart();
    start_play(24'd2, 7'd1);
    repeat (32) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fin_done: got %0b expected 1", done); end
    start_play(24'd2, 7'd1);
    checks++; if (play !== 1'b1) begin errors++; $display("FAIL fin_play: got %0b expected 1", play); end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL fin_step: got %0b expected 1", step); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fin_done_after: got %0b expected 0", done); end
    stop_play();
  endtask

  // StepPeriod below 2 is clamped to 2.
  task automatic test_clamp();
    int second, done_cyc, n;
    second = -1; done_cyc = -1; n = 0;
    start_play(24'd1, 7'd1);
    for (int c = 1; c <= 34; c++) begin
      if (step) begin n++; if (n == 2) second = c; end
      if (done) done_cyc = c;
      @(negedge clk);
    end
    checks++; if (second != 3) begin errors++; $display("FAIL clamp1_second: got %0d expected 3", second); end
    checks++; if (done_cyc != 33) begin errors++; $display("FAIL clamp1_done: got %0d expected 33", done_cyc); end
    start_play(24'd0, 7'd0);
    @(negedge clk);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL clamp0_c2: got %0b expected 0", step); end
    @(negedge clk);
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL clamp0_c3: got %0b expected 1", step); end
    stop_play();
  endtask

`ifdef SWING_EN
  // P=10, Swing=9 -> S=5: gaps 15/5 alternate; 16 steps still span 160 cycles.
  task automatic test_swing();
    int cyc[$];
    int done_cyc;
    done_cyc = -1;
    swing = 23'd9;
    start_play(24'd10, 7'd1);
    for (int c = 1; c <= 162; c++) begin
      if (step) cyc.push_back(c);
      if (done) done_cyc = c;
      @(negedge clk);
    end
    checks++; if (cyc.size() != 16) begin errors++; $display("FAIL swing_cnt: got %0d expected 16", cyc.size()); end
    if (cyc.size() >= 4) begin
      checks++; if (cyc[1] != 16) begin errors++; $display("FAIL swing_gap0: got %0d expected 16", cyc[1]); end
      checks++; if (cyc[2] != 21) begin errors++; $display("FAIL swing_gap1: got %0d expected 21", cyc[2]); end
      checks++; if (cyc[3] != 36) begin errors++; $display("FAIL swing_gap2: got %0d expected 36", cyc[3]); end
    end
    checks++; if (done_cyc != 161) begin errors++; $display("FAIL swing_done: got %0d expected 161", done_cyc); end
    swing = '0;
  endtask
`endif

  // Test sequence and final report.
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    step_period = '0; loops = '0; pattern = '0;
`ifdef SWING_EN
    swing = '0;
`endif
    @(negedge clk);
    test_reset();
    test_loop_timing();
    test_pattern();
    test_infinite_stop();
    test_start_stop_collision();
    test_back_to_back();
    test_fin_restart();
    test_clamp();
`ifdef SWING_EN
    test_swing();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
